bwt_occ_req_tracker: RTL and testbench
======================================

Name: bwt_occ_req_tracker

Overview:
- Parametrised memory-request tracker placed between NUM_CH BWT-extend pipelines and the single occurrence-table DRAM port.
- Arbitrates the per-channel (addr_k, addr_l) occurrence requests onto one tagged DRAM request stream.
- Tracks up to MAX_OUT outstanding requests and routes each returned response (cnt_a/cnt_b/cntl_a/cntl_b bundle) back to the channel that issued it.
- Supports out-of-order DRAM returns. Earlier generations assumed strictly in-order, single-channel returns.

Parameters:
- NUM_CH, 4, number of requesting pipeline channels (1..16).
- MAX_OUT, 16, maximum outstanding DRAM requests; must be a power of 2.
- TAG_W, 4, tag width; equals log2(MAX_OUT).
- ADDR_W, 32, width of addr_k and addr_l.
- RESP_W, 768, response payload width: cnt_a0..3 (4x32), cnt_b0..3 (4x64), cntl_a0..3 (4x32), cntl_b0..3 (4x64), packed in that order from the LSB.

Ports:
- Clk_32UI  in  1  clock; all logic on the rising edge.
- reset_BWT_extend  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_addr_k  in  NUM_CH*ADDR_W  per-channel k address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_addr_l  in  NUM_CH*ADDR_W  per-channel l address; same packing as req_addr_k.
- req_ready  out  NUM_CH  one-hot accept, combinational.
- DRAM_valid  out  1  registered request valid.
- addr_k  out  ADDR_W  registered request k address.
- addr_l  out  ADDR_W  registered request l address.
- DRAM_tag  out  TAG_W  registered request tag.
- DRAM_ready  in  1  DRAM accepts the request when DRAM_valid=1 and DRAM_ready=1.
- DRAM_get  in  1  response valid (no backpressure).
- DRAM_get_tag  in  TAG_W  tag of the response.
- DRAM_resp  in  RESP_W  response payload.
- resp_valid  out  NUM_CH  one-hot, registered per-channel response strobe.
- resp_data  out  RESP_W  registered payload, shared by all channels.
- outstanding  out  TAG_W+1  number of tags currently in flight.
- resp_err  out  1  sticky flag: a response arrived for a tag that is not in flight.

Behaviour:
- Reset (asynchronous) clears the following, all to 0:
  - req_ready, DRAM_valid, addr_k, addr_l, DRAM_tag
  - resp_valid, resp_data, outstanding, resp_err
  - all tag-table busy bits
  - round-robin pointer (points at channel 0)
- Tag table: MAX_OUT entries, each holding a busy bit and the owning channel index.
- Issue slot is "free" when DRAM_valid=0, or when DRAM_valid=1 and DRAM_ready=1 in the same cycle.
- Accept condition: slot free AND at least one tag not busy AND any req_valid=1.
  - The grant goes to the first requesting channel at or after the RR pointer, wrapping around.
  - req_ready is asserted for the granted channel only, in the same cycle.
- On accept, at the clock edge:
  - DRAM_valid<=1; addr_k/addr_l<=the granted channel's addresses.
  - DRAM_tag<=lowest-index non-busy tag; that tag becomes busy with owner=granted channel.
  - RR pointer<=granted channel+1, mod NUM_CH.
- Handshake hold: while DRAM_valid=1 and DRAM_ready=0, addr_k, addr_l and DRAM_tag stay stable.
- Slot free with no accept: DRAM_valid<=0.
- Tag allocation uses the pre-edge busy set, so a tag freed in cycle n is reusable from cycle n+1.
- Table full (all tags busy): req_ready=0 for every channel; pending requests wait. The request already in the output register is unaffected.
- Response with DRAM_get=1 and the tag busy, at the edge:
  - resp_valid[owner]<=1; resp_data<=DRAM_resp.
  - The tag is cleared.
  - Latency: 1 cycle from DRAM_get to resp_valid.
- Response with DRAM_get=1 and the tag not busy:
  - resp_err<=1 (sticky until reset).
  - resp_valid<=0; table unchanged.
- resp_valid is a single-cycle pulse.
- resp_data holds its last value when no response arrives.
- outstanding: +1 on accept, -1 on a valid response, unchanged when both occur in the same cycle. Never exceeds MAX_OUT.
- Reset mid-operation drops every in-flight tag. Later responses carrying those tags set resp_err.

Test Plan:
- Reset, then 3 requests on ch0 with addresses k=0x10/l=0x20, 0x30/0x40, 0x50/0x60, DRAM_ready=1 -> DRAM_tag 0,1,2 on consecutive cycles; outstanding=3.
- req_valid=4'b1111 held, DRAM_ready=1 -> grants in order ch0,ch1,ch2,ch3,ch0; req_ready one-hot each cycle.
- Tags 0,1,2 outstanding; responses return in tag order 2,0,1 with payloads 0xA,0xB,0xC -> one cycle after each, resp_valid pulses for the owning channel with the matching resp_data; outstanding ends at 0.
- Issue 16 requests with no responses -> outstanding=16, req_ready=0. Then return tag 5 -> tag 5 is reissued on the next accept.
- DRAM_ready=0 for 4 cycles with DRAM_valid=1 -> addr_k, addr_l and DRAM_tag stay constant; no req_ready asserted.
- Response with tag 7 while tag 7 is idle -> resp_err=1 and it stays 1; no resp_valid. Then assert reset_BWT_extend mid-flight -> all outputs 0 and outstanding=0.

Source files
------------

// File: rtl/bwt_occ_req_tracker.sv
// bwt_occ_req_tracker: round-robin arbiter and tag table between NUM_CH BWT-extend pipelines
// and one occurrence-table DRAM port, routing out-of-order tagged responses back to their channel.
module bwt_occ_req_tracker #(
   parameter int NUM_CH  = 4,
   parameter int MAX_OUT = 16,
   parameter int TAG_W   = 4,
   parameter int ADDR_W  = 32,
   parameter int RESP_W  = 768
) (
   input  logic                     Clk_32UI,
   input  logic                     reset_BWT_extend,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr_k,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr_l,
   output logic [NUM_CH-1:0]        req_ready,
   output logic                     DRAM_valid,
   output logic [ADDR_W-1:0]        addr_k,
   output logic [ADDR_W-1:0]        addr_l,
   output logic [TAG_W-1:0]         DRAM_tag,
   input  logic                     DRAM_ready,
   input  logic                     DRAM_get,
   input  logic [TAG_W-1:0]         DRAM_get_tag,
   input  logic [RESP_W-1:0]        DRAM_resp,
   output logic [NUM_CH-1:0]        resp_valid,
   output logic [RESP_W-1:0]        resp_data,
   output logic [TAG_W:0]           outstanding,
   output logic                     resp_err
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

   logic [MAX_OUT-1:0] busy;
   logic [CH_W-1:0]    owner [MAX_OUT];
   logic [CH_W-1:0]    rr_ptr, grant, cand;
   logic [CH_W:0]      sum;
   logic [TAG_W-1:0]   free_tag;
   logic               found, accept, get_hit, get_miss;

   // first requester at or after the round-robin pointer, wrapping
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum  = {1'b0, rr_ptr} + (CH_W+1)'(i);
         cand = sum >= (CH_W+1)'(NUM_CH) ? CH_W'(sum - (CH_W+1)'(NUM_CH)) : CH_W'(sum);
         if (!found && req_valid[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      free_tag = '0;
      for (int t = MAX_OUT - 1; t >= 0; t--)
         if (!busy[t]) free_tag = TAG_W'(t);
   end

   assign accept    = !reset_BWT_extend && (!DRAM_valid || DRAM_ready) && !(&busy) && found;
   assign req_ready = accept ? NUM_CH'(1) << grant : '0;
   assign get_hit   = DRAM_get && busy[DRAM_get_tag];
   assign get_miss  = DRAM_get && !busy[DRAM_get_tag];

   always_ff @(posedge Clk_32UI or posedge reset_BWT_extend) begin
      if (reset_BWT_extend) begin
         DRAM_valid  <= 1'b0;
         addr_k      <= '0;
         addr_l      <= '0;
         DRAM_tag    <= '0;
         resp_valid  <= '0;
         resp_data   <= '0;
         outstanding <= '0;
         resp_err    <= 1'b0;
         busy        <= '0;
         rr_ptr      <= '0;
         for (int t = 0; t < MAX_OUT; t++) owner[t] <= '0;
      end else begin
         if (accept) begin
            DRAM_valid <= 1'b1;
            addr_k     <= req_addr_k[grant*ADDR_W +: ADDR_W];
            addr_l     <= req_addr_l[grant*ADDR_W +: ADDR_W];
            DRAM_tag   <= free_tag;
            rr_ptr     <= grant == CH_W'(NUM_CH - 1) ? '0 : grant + 1'b1;
         end else if (!DRAM_valid || DRAM_ready) begin
            DRAM_valid <= 1'b0;
         end
         // allocated tag was idle pre-edge and the returning tag was busy, so they never collide
         if (get_hit) busy[DRAM_get_tag] <= 1'b0;
         if (accept) begin
            busy[free_tag]  <= 1'b1;
            owner[free_tag] <= grant;
         end
         resp_valid <= get_hit ? NUM_CH'(1) << owner[DRAM_get_tag] : '0;
         if (get_hit) resp_data <= DRAM_resp;
         if (get_miss) resp_err <= 1'b1;
         outstanding <= outstanding + (TAG_W+1)'(accept) - (TAG_W+1)'(get_hit);
      end
   end
endmodule

// File: tb/tb_bwt_occ_req_tracker.sv
// tb_bwt_occ_req_tracker: directed scenario tasks with inline checks against hand-computed values.
module tb_bwt_occ_req_tracker;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_addr_k, req_addr_l;
   logic [3:0]   req_ready;
   logic         DRAM_valid;
   logic [31:0]  addr_k, addr_l;
   logic [3:0]   DRAM_tag;
   logic         DRAM_ready, DRAM_get;
   logic [3:0]   DRAM_get_tag;
   logic [767:0] DRAM_resp;
   logic [3:0]   resp_valid;
   logic [767:0] resp_data;
   logic [4:0]   outstanding;
   logic         resp_err;
   int checks = 0;
   int passed = 0;

   bwt_occ_req_tracker #(.NUM_CH(4), .MAX_OUT(16), .TAG_W(4), .ADDR_W(32), .RESP_W(768)) dut (
      .Clk_32UI(clk), .reset_BWT_extend(rst), .req_valid(req_valid), .req_addr_k(req_addr_k),
      .req_addr_l(req_addr_l), .req_ready(req_ready), .DRAM_valid(DRAM_valid), .addr_k(addr_k),
      .addr_l(addr_l), .DRAM_tag(DRAM_tag), .DRAM_ready(DRAM_ready), .DRAM_get(DRAM_get),
      .DRAM_get_tag(DRAM_get_tag), .DRAM_resp(DRAM_resp), .resp_valid(resp_valid),
      .resp_data(resp_data), .outstanding(outstanding), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0; req_addr_k = '0; req_addr_l = '0;
      DRAM_ready = 1'b0; DRAM_get = 1'b0; DRAM_get_tag = '0; DRAM_resp = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'hF; req_addr_k = '0; req_addr_l = '0;
      DRAM_ready = 1'b1; DRAM_get = 1'b0; DRAM_get_tag = '0; DRAM_resp = '0;
      tick();
      checks++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passed++;
      checks++; if (DRAM_valid !== 1'b0) $display("FAIL reset_dram_valid: got %b want 0", DRAM_valid); else passed++;
      checks++; if (addr_k !== 32'h0 || addr_l !== 32'h0) $display("FAIL reset_addr: got %h/%h want 0/0", addr_k, addr_l); else passed++;
      checks++; if (DRAM_tag !== 4'h0) $display("FAIL reset_tag: got %0d want 0", DRAM_tag); else passed++;
      checks++; if (resp_valid !== 4'h0) $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); else passed++;
      checks++; if (resp_data !== 768'h0) $display("FAIL reset_resp_data: got %0h want 0", resp_data); else passed++;
      checks++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else passed++;
      checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err); else passed++;
      req_valid = '0;
      DRAM_ready = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_issue();
      DRAM_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 4'b0001;
         req_addr_k[31:0] = 32'h10 + 32'h20 * i;
         req_addr_l[31:0] = 32'h20 + 32'h20 * i;
         #1;
         checks++; if (req_ready !== 4'b0001) $display("FAIL issue_ready%0d: got %b want 0001", i, req_ready); else passed++;
         tick();
         checks++; if (DRAM_valid !== 1'b1 || DRAM_tag !== 4'(i)) $display("FAIL issue_tag%0d: got v=%b tag=%0d want v=1 tag=%0d", i, DRAM_valid, DRAM_tag, i); else passed++;
         checks++; if (addr_k !== 32'h10 + 32'h20 * i || addr_l !== 32'h20 + 32'h20 * i) $display("FAIL issue_addr%0d: got %h/%h want %h/%h", i, addr_k, addr_l, 32'h10 + 32'h20 * i, 32'h20 + 32'h20 * i); else passed++;
      end
      req_valid = '0;
      tick();
      checks++; if (DRAM_valid !== 1'b0) $display("FAIL issue_idle_valid: got %b want 0", DRAM_valid); else passed++;
      checks++; if (outstanding !== 5'd3) $display("FAIL issue_outstanding: got %0d want 3", outstanding); else passed++;
   endtask

   task automatic test_out_of_order();
      logic [3:0]  tags [3] = '{4'd2, 4'd0, 4'd1};
      logic [15:0] pays [3] = '{16'hA, 16'hB, 16'hC};
      for (int j = 0; j < 3; j++) begin
         DRAM_get = 1'b1; DRAM_get_tag = tags[j]; DRAM_resp = 768'(pays[j]);
         tick();
         checks++; if (resp_valid !== 4'b0001 || resp_data !== 768'(pays[j])) $display("FAIL ooo_resp%0d: got %b/%0h want 0001/%0h", j, resp_valid, resp_data, pays[j]); else passed++;
         checks++; if (outstanding !== 5'(2 - j)) $display("FAIL ooo_outstanding%0d: got %0d want %0d", j, outstanding, 2 - j); else passed++;
      end
      DRAM_get = 1'b0; DRAM_resp = '0;
      tick();
      checks++; if (resp_valid !== 4'b0000 || resp_data !== 768'hC) $display("FAIL ooo_pulse_hold: got %b/%0h want 0000/c", resp_valid, resp_data); else passed++;
      checks++; if (outstanding !== 5'd0) $display("FAIL ooo_final_outstanding: got %0d want 0", outstanding); else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0]  tags [3] = '{4'd4, 4'd1, 4'd3};
      logic [3:0]  chs  [3] = '{4'b0001, 4'b0010, 4'b1000};
      logic [15:0] pays [3] = '{16'h111, 16'h222, 16'h333};
      do_reset();
      DRAM_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         req_addr_k[c*32 +: 32] = 32'h100 * (c + 1);
         req_addr_l[c*32 +: 32] = 32'h1000 * (c + 1);
      end
      req_valid = 4'hF;
      for (int j = 0; j < 5; j++) begin
         #1;
         checks++; if (req_ready !== 4'(1 << (j % 4))) $display("FAIL rr_ready%0d: got %b want %b", j, req_ready, 4'(1 << (j % 4))); else passed++;
         tick();
         checks++; if (DRAM_tag !== 4'(j) || addr_k !== 32'h100 * ((j % 4) + 1)) $display("FAIL rr_issue%0d: got tag=%0d k=%h want tag=%0d k=%h", j, DRAM_tag, addr_k, j, 32'h100 * ((j % 4) + 1)); else passed++;
      end
      req_valid = '0;
      for (int j = 0; j < 3; j++) begin
         DRAM_get = 1'b1; DRAM_get_tag = tags[j]; DRAM_resp = 768'(pays[j]);
         tick();
         checks++; if (resp_valid !== chs[j] || resp_data !== 768'(pays[j])) $display("FAIL rr_route%0d: got %b/%0h want %b/%0h", j, resp_valid, resp_data, chs[j], pays[j]); else passed++;
      end
      DRAM_get = 1'b0;
      tick();
      checks++; if (resp_valid !== 4'b0000 || outstanding !== 5'd2) $display("FAIL rr_tail: got %b/%0d want 0000/2", resp_valid, outstanding); else passed++;
   endtask

   task automatic test_full();
      do_reset();
      DRAM_ready = 1'b1;
      req_valid = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         req_addr_k[31:0] = 32'(i);
         tick();
         checks++; if (DRAM_tag !== 4'(i)) $display("FAIL full_tag%0d: got %0d want %0d", i, DRAM_tag, i); else passed++;
      end
      checks++; if (req_ready !== 4'b0000 || outstanding !== 5'd16) $display("FAIL full_block: got %b/%0d want 0000/16", req_ready, outstanding); else passed++;
      tick();
      checks++; if (DRAM_valid !== 1'b0 || outstanding !== 5'd16) $display("FAIL full_drain: got %b/%0d want 0/16", DRAM_valid, outstanding); else passed++;
      DRAM_get = 1'b1; DRAM_get_tag = 4'd5; DRAM_resp = 768'h55;
      #1;
      checks++; if (req_ready !== 4'b0000) $display("FAIL full_ready_pre_free: got %b want 0000", req_ready); else passed++;
      tick();
      DRAM_get = 1'b0;
      #1;
      checks++; if (resp_valid !== 4'b0001 || outstanding !== 5'd15) $display("FAIL full_free5: got %b/%0d want 0001/15", resp_valid, outstanding); else passed++;
      checks++; if (req_ready !== 4'b0001) $display("FAIL full_ready_post_free: got %b want 0001", req_ready); else passed++;
      tick();
      checks++; if (DRAM_valid !== 1'b1 || DRAM_tag !== 4'd5 || outstanding !== 5'd16) $display("FAIL full_reissue: got v=%b tag=%0d out=%0d want 1/5/16", DRAM_valid, DRAM_tag, outstanding); else passed++;
      req_valid = '0;
   endtask

   task automatic test_hold();
      do_reset();
      DRAM_ready = 1'b1;
      req_valid = 4'b0001;
      req_addr_k[31:0] = 32'h111; req_addr_l[31:0] = 32'h222;
      tick();
      checks++; if (DRAM_valid !== 1'b1 || DRAM_tag !== 4'd0) $display("FAIL hold_first: got %b/%0d want 1/0", DRAM_valid, DRAM_tag); else passed++;
      DRAM_ready = 1'b0;
      req_addr_k[31:0] = 32'h999; req_addr_l[31:0] = 32'hAAA;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) $display("FAIL hold_ready%0d: got %b want 0000", i, req_ready); else passed++;
         tick();
         checks++; if (DRAM_valid !== 1'b1 || addr_k !== 32'h111 || addr_l !== 32'h222 || DRAM_tag !== 4'd0) $display("FAIL hold_stable%0d: got v=%b %h/%h tag=%0d want 1 111/222 tag=0", i, DRAM_valid, addr_k, addr_l, DRAM_tag); else passed++;
      end
      DRAM_ready = 1'b1;
      DRAM_get = 1'b1; DRAM_get_tag = 4'd0; DRAM_resp = 768'h77;
      #1;
      checks++; if (req_ready !== 4'b0001) $display("FAIL hold_release_ready: got %b want 0001", req_ready); else passed++;
      tick();
      DRAM_get = 1'b0; req_valid = '0;
      checks++; if (addr_k !== 32'h999 || DRAM_tag !== 4'd1) $display("FAIL hold_next: got %h/%0d want 999/1", addr_k, DRAM_tag); else passed++;
      checks++; if (resp_valid !== 4'b0001 || outstanding !== 5'd1) $display("FAIL hold_concurrent: got %b/%0d want 0001/1", resp_valid, outstanding); else passed++;
   endtask

   task automatic test_err_reset();
      DRAM_get = 1'b1; DRAM_get_tag = 4'd7; DRAM_resp = 768'hEE;
      tick();
      DRAM_get = 1'b0;
      checks++; if (resp_err !== 1'b1 || resp_valid !== 4'b0000) $display("FAIL err_set: got %b/%b want 1/0000", resp_err, resp_valid); else passed++;
      checks++; if (resp_data !== 768'h77 || outstanding !== 5'd1) $display("FAIL err_no_change: got %0h/%0d want 77/1", resp_data, outstanding); else passed++;
      repeat (3) tick();
      checks++; if (resp_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", resp_err); else passed++;
      req_valid = 4'b0001; req_addr_k[31:0] = 32'h5;
      tick();
      checks++; if (DRAM_valid !== 1'b1 || DRAM_tag !== 4'd0 || outstanding !== 5'd2) $display("FAIL err_inflight: got v=%b tag=%0d out=%0d want 1/0/2", DRAM_valid, DRAM_tag, outstanding); else passed++;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (DRAM_valid !== 1'b0 || addr_k !== 32'h0 || DRAM_tag !== 4'd0 || req_ready !== 4'b0000) $display("FAIL async_reset_req: got v=%b k=%h tag=%0d rdy=%b want 0/0/0/0000", DRAM_valid, addr_k, DRAM_tag, req_ready); else passed++;
      checks++; if (outstanding !== 5'd0 || resp_err !== 1'b0 || resp_data !== 768'h0) $display("FAIL async_reset_resp: got out=%0d err=%b data=%0h want 0/0/0", outstanding, resp_err, resp_data); else passed++;
      tick();
      rst = 1'b0; req_valid = '0;
      DRAM_get = 1'b1; DRAM_get_tag = 4'd1; DRAM_resp = 768'h99;
      tick();
      DRAM_get = 1'b0;
      checks++; if (resp_err !== 1'b1 || resp_valid !== 4'b0000 || outstanding !== 5'd0) $display("FAIL stale_tag: got err=%b v=%b out=%0d want 1/0000/0", resp_err, resp_valid, outstanding); else passed++;
   endtask

   initial begin
      test_reset();
      test_issue();
      test_out_of_order();
      test_round_robin();
      test_full();
      test_hold();
      test_err_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
